// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the single-cycle MIPS datapath.
// Issues one memory request per instruction and holds it for decode until acknowledged.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC         = 32'h0000_3000,
    parameter bit          ADDR_ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_pc,
    output logic [31:0] out_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        stall,
    output logic        addr_err,
    output logic [31:0] fetch_cnt
);

    // Handshakes: imem_req/imem_ready complete a fetch in any cycle where both are 1;
    // instr_valid/instr_ack complete delivery in any cycle where both are 1 and stall is 0.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic fetch_done;
    logic ack_ok;
    logic misaligned;
    logic halt_on_ack;

    assign misaligned  = (in_pc[1:0] != 2'b00);
    assign halt_on_ack = ADDR_ALIGN_CHECK && misaligned;
    assign fetch_done  = (state == FETCH) && imem_req && imem_ready;
    assign ack_ok      = (state == HOLD) && instr_ack && !stall;
    assign imem_addr   = out_pc;

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            BOOT: begin
                if (!stall) state_next = FETCH;
            end
            FETCH: begin
                imem_req = !stall;
                if (!stall && imem_ready) state_next = HOLD;
            end
            HOLD: begin
                if (ack_ok) state_next = halt_on_ack ? HALT : FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pc      <= RESET_PC;
            instr       <= 32'h0000_0000;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            fetch_cnt   <= 32'h0000_0000;
        end else begin
            if (fetch_done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (ack_ok) begin
                fetch_cnt   <= fetch_cnt + 32'd1;
                instr_valid <= 1'b0;
                // A faulting target leaves the PC on the instruction that produced it.
                if (halt_on_ack) addr_err <= 1'b1;
                else             out_pc   <= {in_pc[31:2], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized fetch transactions checked against a transaction-level PC model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_pc;
    logic [31:0] out_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        stall;
    logic        addr_err;
    logic [31:0] fetch_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: architectural PC, retired-fetch count, sticky error.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC(RESET_PC),
        .ADDR_ALIGN_CHECK(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_pc(in_pc),
        .out_pc(out_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ack(instr_ack),
        .stall(stall),
        .addr_err(addr_err),
        .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req();
        int t = 0;
        while (imem_req !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_cnt = 32'd0;
        m_err = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},    out_pc, RESET_PC);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_err"},   {31'd0, addr_err}, 32'd0);
        chk({tag, "_cnt"},   fetch_cnt, 32'd0);
    endtask

    // One instruction: memory latency lat, stalled acks, then an accepted ack with npc.
    task automatic do_fetch(input int lat, input logic [31:0] rdata, input logic [31:0] npc,
                            input int stalls, input bit preload);
        wait_req();
        chk("imem_addr", imem_addr, m_pc);
        if (stalls > 0) begin
            stall = 1'b1;
            imem_ready = 1'b1;
            step();
            chk("req_stalled", {31'd0, imem_req}, 32'd0);
            chk("valid_stalled", {31'd0, instr_valid}, 32'd0);
            stall = 1'b0;
            imem_ready = 1'b0;
            #1;
            chk("req_resume", {31'd0, imem_req}, 32'd1);
        end
        for (int i = 1; i < lat; i++) begin
            instr_ack  = 1'($urandom_range(0, 1));
            in_pc      = $urandom;
            imem_rdata = $urandom;
            step();
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("valid_low", {31'd0, instr_valid}, 32'd0);
            chk("pc_in_fetch", out_pc, m_pc);
        end
        instr_ack  = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("instr", instr, rdata);
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("req_in_hold", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < stalls; i++) begin
            stall     = 1'b1;
            instr_ack = 1'b1;
            in_pc     = $urandom;
            step();
            chk("pc_stall", out_pc, m_pc);
            chk("valid_stall", {31'd0, instr_valid}, 32'd1);
            chk("instr_stable", instr, rdata);
        end
        if (preload) begin
            force dut.fetch_cnt = 32'hFFFF_FFFF;
            #1;
            release dut.fetch_cnt;
            m_cnt = 32'hFFFF_FFFF;
            chk("cnt_preload", fetch_cnt, m_cnt);
        end
        stall     = 1'b0;
        instr_ack = 1'b1;
        in_pc     = npc;
        step();
        instr_ack = 1'b0;
        m_cnt = m_cnt + 32'd1;
        if (npc[1:0] != 2'b00) m_err = 1'b1;
        else                   m_pc  = npc;
        chk("pc_after_ack", out_pc, m_pc);
        chk("cnt_after_ack", fetch_cnt, m_cnt);
        chk("err_after_ack", {31'd0, addr_err}, {31'd0, m_err});
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] npc;
        rst        = 1'b1;
        in_pc      = 32'd0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        instr_ack  = 1'b0;
        stall      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        chk("rst_instr", instr, 32'd0);

        rst = 1'b0;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        do_fetch(1, 32'h2008_0005, 32'h0000_3004, 0, 1'b0);
        do_fetch(3, 32'h1000_000F, 32'h0000_3040, 0, 1'b0);
        do_fetch(1, 32'h0000_0000, 32'h0000_3044, 2, 1'b0);

        for (int k = 0; k < 20; k++) begin
            npc = $urandom;
            npc[1:0] = 2'b00;
            do_fetch($urandom_range(1, 4), $urandom, npc, $urandom_range(0, 2), 1'b0);
        end

        do_fetch(2, $urandom, 32'h0000_3100, 0, 1'b1);
        chk("cnt_wrapped", fetch_cnt, 32'd0);

        // Async reset between edges while a request is outstanding.
        wait_req();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("async_rst");
        @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        chk("rst_ready_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_ready_instr", instr, 32'd0);
        rst = 1'b0;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("boot_ready_valid", {31'd0, instr_valid}, 32'd0);
        chk("boot_ready_instr", instr, 32'd0);

        do_fetch(2, 32'h2108_0001, 32'h0000_3004, 1, 1'b0);
        do_fetch(2, 32'h0800_0C00, 32'h0000_3006, 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'($urandom_range(0, 1));
            instr_ack  = 1'b1;
            in_pc      = $urandom;
            step();
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_err", {31'd0, addr_err}, 32'd1);
            chk("halt_pc", out_pc, m_pc);
            chk("halt_cnt", fetch_cnt, m_cnt);
        end
        imem_ready = 1'b0;
        instr_ack  = 1'b0;

        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("halt_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and the instruction-fetch handshake for the single-cycle MIPS datapath.
- Drives `out_pc` to the next-PC calculator and consumes its `in_pc` result.
- Fetches from instruction memory with a request/ready handshake and presents the instruction to decode with a valid/ack handshake.
- Flags misaligned next-PC values and counts retired fetches.

Parameters:
- RESET_PC, 32'h00003000, PC loaded on reset; the first fetch address.
- ADDR_ALIGN_CHECK, 1, when 1 a misaligned `in_pc` (bits[1:0]≠0) raises `addr_err` and halts; when 0 the low bits are forced to 0.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_pc  input  32  next PC from the next-PC calculator; sampled only on an accepted ack.
- out_pc  output  32  current PC register; feeds the next-PC calculator and the PC+4 link path.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals `out_pc` whenever `imem_req`=1.
- imem_ready  input  1  memory response strobe; `imem_rdata` is valid in the same cycle.
- imem_rdata  input  32  instruction word from memory.
- instr  output  32  latched instruction presented to decode.
- instr_valid  output  1  `instr` is valid for `out_pc`.
- instr_ack  input  1  decode/execute consumed the instruction; PC may advance.
- stall  input  1  holds the PC; suppresses ack acceptance and new requests.
- addr_err  output  1  sticky misaligned-next-PC error.
- fetch_cnt  output  32  number of accepted acks; wraps.

Behaviour:
- Reset (async, any state):
  - `out_pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `addr_err`=0, `fetch_cnt`=0.
  - State=BOOT.
- FSM states: BOOT, FETCH, HOLD, HALT.
- BOOT: one cycle after reset release, `imem_req`=0; next state FETCH. A stall in BOOT delays the exit until stall=0.
- FETCH:
  - `imem_req`=1 while stall=0; `imem_addr`=`out_pc`. With stall=1, `imem_req`=0 and the state is held.
  - On `imem_ready`=1 with `imem_req`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, next state HOLD.
  - `imem_ready` while `imem_req`=0 is ignored.
  - Minimum fetch latency is 1 cycle from req assertion to `instr_valid`.
- HOLD:
  - `instr_valid`=1, `imem_req`=0.
  - On `instr_ack`=1 and stall=0 (accepted ack):
    - `out_pc`<=`in_pc`, `fetch_cnt`<=`fetch_cnt`+1 (modulo 2^32, 0xFFFFFFFF→0), `instr_valid`<=0.
    - Next state FETCH.
  - An ack while stall=1 is ignored; the state stays HOLD.
  - `instr` is stable for the entire HOLD state.
- Misalignment check: evaluated on accepted ack, in_pc[1:0]≠0.
  - ADDR_ALIGN_CHECK=1: `out_pc` is NOT updated, `fetch_cnt` still increments, `addr_err`<=1, `instr_valid`<=0, next state HALT.
  - ADDR_ALIGN_CHECK=0: `out_pc`<={in_pc[31:2],2'b00}; no error.
- HALT: all outputs hold; `imem_req`=0, `instr_valid`=0. Only reset exits HALT. `addr_err` is sticky until reset.
- `out_pc` changes only on an accepted ack or on reset.
- An ack in FETCH/BOOT/HALT has no effect.
- Reset mid-fetch: the pending memory response is dropped. A response arriving after reset release, before the new FETCH req, is ignored.
- All registered outputs update on the rising clk edge. `imem_req` and `imem_addr` are decoded from the state plus stall.

Test Plan:
- Reset release, `imem_ready` asserted 1 cycle after req, rdata=0x20080005, in_pc=0x00003004, ack next cycle.
  - `imem_addr`=0x00003000.
  - `instr`=0x20080005 with `instr_valid`=1.
  - After ack: `out_pc`=0x00003004, `fetch_cnt`=1, next req at 0x00003004.
- Memory latency 3 cycles, then a branch redirect in_pc=0x00003040.
  - `imem_req` held 3 cycles with `instr_valid`=0.
  - After ack: `out_pc`=0x00003040.
- In HOLD, ack=1 with stall=1 for 2 cycles, then stall=0.
  - `out_pc` unchanged, `instr_valid` stays 1 during the stall.
  - Advance happens only in the cycle stall=0.
- ADDR_ALIGN_CHECK=1, in_pc=0x00003006 on ack.
  - `addr_err`=1, `out_pc` unchanged (old value), `imem_req`=0 forever.
  - Assert rst: `addr_err`=0, `out_pc`=0x00003000.
- Async reset asserted mid-FETCH between clock edges.
  - Outputs reach reset values immediately.
  - `imem_ready` pulse during reset is ignored, `instr_valid`=0.
- Preload `fetch_cnt` near wrap (force to 0xFFFFFFFF), one accepted ack → `fetch_cnt`=0x00000000.
